// File: rtl/mealy_fsm_ol.sv
// Overlapping serial detector for the pattern 1101 (first-received bit first).
// Mealy machine: the detect flag is a combinational function of the current
// state and the bit presented on 'in', so a match is flagged in the same
// cycle as the fourth pattern bit, before the edge that consumes it.
module mealy_fsm_ol (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    // Each state names the longest prefix of 1101 that is also a suffix of
    // the bits consumed so far. All four 2-bit codes are used.
    typedef enum logic [1:0] {
        S0   = 2'b00,   // nothing matched
        S1   = 2'b01,   // matched "1"
        S11  = 2'b10,   // matched "11"
        S110 = 2'b11    // matched "110"
    } state_t;

    state_t state_reg;
    state_t state_next;

    // State register; reset forces S0 at once, without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S0;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and detect-flag decode. After a hit the trailing 1 is kept as
    // the start of the next match, so the machine lands in S1 rather than S0.
    // The flag is also held low while rst is asserted, so it never depends on
    // clock activity during reset.
    always_comb begin
        state_next = S0;
        out        = 1'b0;
        case (state_reg)
            S0: begin
                state_next = in ? S1 : S0;
            end
            S1: begin
                state_next = in ? S11 : S0;
            end
            S11: begin
                // Additional 1s still leave "11" as the useful suffix.
                state_next = in ? S11 : S110;
            end
            S110: begin
                state_next = in ? S1 : S0;
                out        = in & ~rst;
            end
            default: begin
                state_next = S0;
            end
        endcase
    end

endmodule

// File: tb/tb_mealy_fsm_ol.sv
// Self-checking bench for the 1101 overlapping Mealy detector. The reference
// model keeps the bits seen since reset and declares a hit whenever the three
// previous bits are 1,1,0 and the bit currently applied is 1.
module tb_mealy_fsm_ol;

    logic clk;
    logic rst;
    logic in;
    logic out;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    // Reference model state: last three consumed bits (oldest in bit 2) and
    // how many bits have been consumed since reset was released.
    logic [2:0] hist = 3'b000;
    int         nbits = 0;

    mealy_fsm_ol dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .out (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required finish before 200000", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic model_out(input logic b);
        return (nbits >= 3) && (hist == 3'b110) && b;
    endfunction

    task automatic check(input string tag, input logic expv);
        checks++;
        assert (out === expv) else begin
            errors++;
            $error("FAIL %s: out=%b expected %b", tag, out, expv);
        end
    endtask

    task automatic check_count(input string tag, input int got, input int want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: pulses=%0d expected %0d", tag, got, want);
        end
    endtask

    // Apply one bit away from the rising edge, compare the combinational flag,
    // then let the following rising edge consume the bit.
    task automatic drive_bit(input string tag, input logic b);
        logic e;
        @(negedge clk);
        in = b;
        #1;
        e = model_out(b);
        check(tag, e);
        if (out === 1'b1) pulses++;
        $display("%-10s in=%b out=%b exp=%b", tag, b, out, e);
        hist  = {hist[1:0], b};
        nbits = nbits + 1;
    endtask

    // Hold reset over several cycles with in toggling; the flag must stay low.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in = 1'(i % 2 == 0);
            #1;
            check("reset_hold", 1'b0);
            $display("reset      in=%b out=%b exp=0", in, out);
            @(negedge clk);
        end
        rst   = 1'b0;
        in    = 1'b0;
        hist  = 3'b000;
        nbits = 0;
    endtask

    task automatic drive_seq(input string tag, input logic [15:0] bits, input int len, input int want);
        pulses = 0;
        for (int i = len - 1; i >= 0; i--) begin
            drive_bit(tag, bits[i]);
        end
        check_count({tag, "_count"}, pulses, want);
    endtask

    initial begin
        rst = 1'b1;
        in  = 1'b0;
        #1;
        check("reset_async_initial", 1'b0);

        // Reset behaviour, then idle zeros.
        do_reset();
        drive_seq("zeros", 16'b000, 3, 0);

        // Single hit, then a trailing 0 confirms the flag dropped after the edge.
        do_reset();
        drive_seq("single", 16'b11010, 5, 1);

        // Overlapping hits.
        do_reset();
        drive_seq("overlap", 16'b1101101, 7, 2);

        // Long run of ones.
        do_reset();
        drive_seq("run1s", 16'b111101, 6, 1);
        do_reset();
        drive_seq("run1100", 16'b11001101, 8, 1);

        // Mid-sequence reset: reach S110, present a 1 (flag high), then assert
        // reset between edges; the flag must drop without a clock edge.
        do_reset();
        drive_seq("pre_rst", 16'b110, 3, 0);
        @(negedge clk);
        in = 1'b1;
        #1;
        check("mid_hit_before_rst", 1'b1);
        rst = 1'b1;
        #1;
        check("mid_async_rst", 1'b0);
        $display("mid_rst    in=%b out=%b exp=0", in, out);
        #2;
        rst   = 1'b0;
        hist  = 3'b000;
        nbits = 0;
        drive_seq("post_rst", 16'b1, 1, 0);
        drive_seq("post_rst2", 16'b101, 3, 1);

        // Periodic 110 stream: 30 bits -> a hit on every period after the first four bits.
        do_reset();
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            drive_bit("periodic", 1'(i % 3 != 2));
        end
        check_count("periodic_count", pulses, 9);

        // Random stream against the model.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            drive_bit("random", 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
